// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant/done buses of the load, store and fetch clients
// plus the command/response bus of the downstream memory controller.
//   master : arbiter side (drives grants, dones, returned data and mc_* commands)
//   slave  : environment side (drives requests, control inputs and mc_done/mc_rdata)
interface mem_arbiter_if;
  logic        rdy_in;
  logic        roll_back;
  logic        io_buffer_full;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [5:0]  ld_op;
  logic        ld_gnt;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        st_req;
  logic [31:0] st_addr;
  logic [5:0]  st_op;
  logic [31:0] st_data;
  logic        st_gnt;
  logic        st_done;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_inst;
  logic [31:0] if_pc_out;
  logic        mc_valid;
  logic [1:0]  mc_kind;
  logic [31:0] mc_addr;
  logic [5:0]  mc_op;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;
  modport master (
    input  rdy_in, roll_back, io_buffer_full,
    input  ld_req, ld_addr, ld_op, st_req, st_addr, st_op, st_data, if_req, if_pc,
    input  mc_done, mc_rdata,
    output ld_gnt, ld_done, ld_data, st_gnt, st_done,
    output if_gnt, if_done, if_inst, if_pc_out,
    output mc_valid, mc_kind, mc_addr, mc_op, mc_wdata
  );
  modport slave (
    output rdy_in, roll_back, io_buffer_full,
    output ld_req, ld_addr, ld_op, st_req, st_addr, st_op, st_data, if_req, if_pc,
    output mc_done, mc_rdata,
    input  ld_gnt, ld_done, ld_data, st_gnt, st_done,
    input  if_gnt, if_done, if_inst, if_pc_out,
    input  mc_valid, mc_kind, mc_addr, mc_op, mc_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates store > load > fetch onto one memory controller, with
// fetch starvation override, IO-full store gating, roll_back flush and rdy_in stall.
//   clk_in : system clock
//   rst_in : asynchronous active-low reset
//   bus    : mem_arbiter_if.master (client requests/grants/dones, mc_* command bus)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk_in,
  input logic           rst_in,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} state_t;
  localparam logic [1:0] K_IF = 2'b00, K_LD = 2'b01, K_ST = 2'b10;
  state_t     state;
  logic [2:0] starve_cnt;
  logic       st_ok, starved, any_req, flush;
  logic [1:0] win;
  always_comb begin
    st_ok   = bus.st_req && !(bus.st_addr[17:16] == 2'b11 && bus.io_buffer_full);
    starved = bus.if_req && starve_cnt == 3'(STARVE_LIMIT);
    any_req = st_ok || bus.ld_req || bus.if_req;
    win     = starved ? K_IF : st_ok ? K_ST : bus.ld_req ? K_LD : K_IF;
    // stores are never aborted by roll_back; loads and fetches are
    flush   = bus.roll_back && bus.mc_kind != K_ST;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.ld_gnt    <= 1'b0;
      bus.st_gnt    <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.ld_done   <= 1'b0;
      bus.st_done   <= 1'b0;
      bus.if_done   <= 1'b0;
      bus.mc_valid  <= 1'b0;
      bus.mc_kind   <= '0;
      bus.mc_addr   <= '0;
      bus.mc_op     <= '0;
      bus.mc_wdata  <= '0;
      bus.ld_data   <= '0;
      bus.if_inst   <= '0;
      bus.if_pc_out <= '0;
    end else if (bus.rdy_in) begin
      bus.ld_gnt   <= 1'b0;
      bus.st_gnt   <= 1'b0;
      bus.if_gnt   <= 1'b0;
      bus.ld_done  <= 1'b0;
      bus.st_done  <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.mc_valid <= 1'b0;
      if (bus.roll_back) starve_cnt <= '0;
      case (state)
        IDLE: begin
          if (!bus.if_req) starve_cnt <= '0;
          if (!bus.roll_back && any_req) begin
            state        <= ISSUE;
            bus.mc_valid <= 1'b1;
            bus.mc_kind  <= win;
            bus.mc_addr  <= win == K_ST ? bus.st_addr : win == K_LD ? bus.ld_addr : bus.if_pc;
            bus.mc_op    <= win == K_ST ? bus.st_op : win == K_LD ? bus.ld_op : '0;
            bus.mc_wdata <= win == K_ST ? bus.st_data : '0;
            bus.st_gnt   <= win == K_ST;
            bus.ld_gnt   <= win == K_LD;
            bus.if_gnt   <= win == K_IF;
            if (bus.if_req)
              starve_cnt <= win == K_IF ? '0 : starve_cnt + 3'(starve_cnt != 3'(STARVE_LIMIT));
          end
        end
        ISSUE: state <= flush ? DRAIN : BUSY;
        BUSY: begin
          if (flush) state <= bus.mc_done ? IDLE : DRAIN;
          else if (bus.mc_done) begin
            state       <= IDLE;
            bus.st_done <= bus.mc_kind == K_ST;
            bus.ld_done <= bus.mc_kind == K_LD;
            bus.if_done <= bus.mc_kind == K_IF;
            if (bus.mc_kind == K_LD) bus.ld_data <= bus.mc_rdata;
            if (bus.mc_kind == K_IF) begin
              bus.if_inst   <= bus.mc_rdata;
              bus.if_pc_out <= bus.mc_addr;
            end
          end
        end
        DRAIN: if (bus.mc_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of priority, starvation, IO gating, flush, stall and reset.
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(4)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk_in);
  endtask
  function automatic logic [31:0] gnts();
    return 32'({bus.st_gnt, bus.ld_gnt, bus.if_gnt});
  endfunction
  function automatic logic [31:0] dones();
    return 32'({bus.st_done, bus.ld_done, bus.if_done});
  endfunction
  // one full transaction granted at the next edge, mc_done three edges after mc_valid
  task automatic serve(input string tag, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] rd, input bit drop);
    logic [31:0] one_hot;
    one_hot = 32'(3'b001 << k);
    step();
    chk({tag, ".valid"}, 32'(bus.mc_valid), 32'd1);
    chk({tag, ".kind"}, 32'(bus.mc_kind), 32'(k));
    chk({tag, ".addr"}, bus.mc_addr, a);
    chk({tag, ".gnt"}, gnts(), one_hot);
    if (drop) begin
      if (k == 2'd2) bus.st_req = 1'b0;
      else if (k == 2'd1) bus.ld_req = 1'b0;
      else bus.if_req = 1'b0;
    end
    step();
    chk({tag, ".valid_off"}, 32'({bus.mc_valid, bus.st_gnt, bus.ld_gnt, bus.if_gnt}), 32'd0);
    step();
    bus.mc_done  = 1'b1;
    bus.mc_rdata = rd;
    step();
    bus.mc_done = 1'b0;
    chk({tag, ".done"}, dones(), one_hot);
    if (k == 2'd1) chk({tag, ".ld_data"}, bus.ld_data, rd);
    if (k == 2'd0) begin
      chk({tag, ".if_inst"}, bus.if_inst, rd);
      chk({tag, ".if_pc_out"}, bus.if_pc_out, a);
    end
  endtask
  initial begin
    bus.rdy_in = 1'b1; bus.roll_back = 1'b0; bus.io_buffer_full = 1'b0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_op = '0;
    bus.st_req = 1'b0; bus.st_addr = '0; bus.st_op = '0; bus.st_data = '0;
    bus.if_req = 1'b0; bus.if_pc = '0;
    bus.mc_done = 1'b0; bus.mc_rdata = '0;
    step();
    step();
    chk("rst.pulses", 32'({bus.mc_valid, gnts()[2:0], dones()[2:0]}), 32'd0);
    chk("rst.mc_addr", bus.mc_addr, 32'd0);
    chk("rst.mc_kind_op", 32'({bus.mc_kind, bus.mc_op}), 32'd0);
    chk("rst.ld_data", bus.ld_data, 32'd0);
    chk("rst.if_inst", bus.if_inst, 32'd0);
    chk("rst.starve", 32'(dut.starve_cnt), 32'd0);
    rst_in = 1'b1;
    // all three requesting: store, then load, then fetch
    bus.st_req = 1'b1; bus.st_addr = 32'h0000_0100; bus.st_op = 6'd3; bus.st_data = 32'h0000_AAAA;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0200; bus.ld_op = 6'd5;
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_1000;
    serve("pri.st", 2'd2, 32'h0000_0100, 32'h0, 1'b1);
    chk("pri.st_op", 32'(bus.mc_op), 32'd3);
    chk("pri.st_wdata", bus.mc_wdata, 32'h0000_AAAA);
    chk("pri.starve1", 32'(dut.starve_cnt), 32'd1);
    serve("pri.ld", 2'd1, 32'h0000_0200, 32'h1111_2222, 1'b1);
    chk("pri.ld_op", 32'(bus.mc_op), 32'd5);
    chk("pri.starve2", 32'(dut.starve_cnt), 32'd2);
    serve("pri.if", 2'd0, 32'h0000_1000, 32'hF00D_0001, 1'b1);
    chk("pri.starve0", 32'(dut.starve_cnt), 32'd0);
    // starvation: four loads, then fetch overrides
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0300;
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_2000;
    for (int i = 0; i < 4; i++) serve("stv.ld", 2'd1, 32'h0000_0300, 32'h3000 + 32'(i), 1'b0);
    chk("stv.starve4", 32'(dut.starve_cnt), 32'd4);
    serve("stv.if", 2'd0, 32'h0000_2000, 32'hF00D_0002, 1'b1);
    bus.ld_req = 1'b0;
    chk("stv.starve0", 32'(dut.starve_cnt), 32'd0);
    // IO-space store blocked while IO buffer full
    bus.st_req = 1'b1; bus.st_addr = 32'h0003_0000; bus.st_data = 32'h5555_0000;
    bus.io_buffer_full = 1'b1;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0400;
    serve("io.ld", 2'd1, 32'h0000_0400, 32'h4444_4444, 1'b1);
    step();
    step();
    chk("io.st_blocked", 32'({bus.mc_valid, bus.st_gnt}), 32'd0);
    bus.io_buffer_full = 1'b0;
    serve("io.st", 2'd2, 32'h0003_0000, 32'h0, 1'b1);
    // roll_back during a fetch in BUSY drains it silently
    bus.if_req = 1'b1; bus.if_pc = 32'h0000_5000;
    step();
    chk("rb.if_gnt", gnts(), 32'd1);
    bus.if_req = 1'b0;
    step();
    bus.roll_back = 1'b1;
    step();
    bus.roll_back = 1'b0;
    step();
    bus.mc_done = 1'b1; bus.mc_rdata = 32'hDEAD_BEEF;
    step();
    bus.mc_done = 1'b0;
    chk("rb.no_if_done", dones(), 32'd0);
    chk("rb.if_inst_kept", bus.if_inst, 32'hF00D_0002);
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0500;
    serve("rb.idle_ld", 2'd1, 32'h0000_0500, 32'h5050_5050, 1'b1);
    // roll_back does not abort a store
    bus.st_req = 1'b1; bus.st_addr = 32'h0000_0600; bus.st_data = 32'h6666_6666;
    step();
    chk("rbs.st_gnt", gnts(), 32'd4);
    bus.st_req = 1'b0;
    step();
    bus.roll_back = 1'b1;
    step();
    bus.roll_back = 1'b0;
    step();
    bus.mc_done = 1'b1; bus.mc_rdata = 32'hDEAD_BEEF;
    step();
    bus.mc_done = 1'b0;
    chk("rbs.st_done", dones(), 32'd4);
    // rdy_in low stretches the ld_done pulse
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0700;
    step();
    chk("rdy.ld_gnt", gnts(), 32'd2);
    bus.ld_req = 1'b0;
    step();
    step();
    bus.mc_done = 1'b1; bus.mc_rdata = 32'h1234_5678;
    step();
    bus.mc_done = 1'b0;
    bus.rdy_in = 1'b0;
    chk("rdy.ld_done", dones(), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy.hold_done", dones(), 32'd2);
      chk("rdy.hold_data", bus.ld_data, 32'h1234_5678);
    end
    bus.rdy_in = 1'b1;
    step();
    chk("rdy.released", dones(), 32'd0);
    // asynchronous reset mid-BUSY
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0800;
    step();
    bus.ld_req = 1'b0;
    step();
    #1 rst_in = 1'b0;
    #1;
    chk("arst.pulses", 32'({bus.mc_valid, gnts()[2:0], dones()[2:0]}), 32'd0);
    chk("arst.mc_addr", bus.mc_addr, 32'd0);
    chk("arst.ld_data", bus.ld_data, 32'd0);
    step();
    rst_in = 1'b1;
    bus.mc_done = 1'b1; bus.mc_rdata = 32'hBAD0_BAD0;
    step();
    bus.mc_done = 1'b0;
    chk("arst.no_stale", 32'({bus.mc_valid, dones()[2:0]}), 32'd0);
    step();
    chk("arst.ld_data0", bus.ld_data, 32'd0);
    // roll_back in IDLE drops the same-cycle request
    bus.ld_req = 1'b1; bus.ld_addr = 32'h0000_0900; bus.roll_back = 1'b1;
    step();
    bus.roll_back = 1'b0;
    chk("rbi.no_grant", 32'({bus.mc_valid, gnts()[2:0]}), 32'd0);
    serve("rbi.ld", 2'd1, 32'h0000_0900, 32'h9999_0000, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive non-fetch grants tolerated while if_req is pending.
REQ-002 SHALL have ports clk_in (in, 1, system clock) and rst_in (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-003 SHALL have rdy_in (in, 1, when low, freeze all state), roll_back (in, 1, mispredict flush) and io_buffer_full (in, 1, IO sink cannot accept a store).
REQ-004 SHALL have ld_req (in, 1), ld_addr (in, 32), ld_op (in, 6), ld_gnt (out, 1, pulse), ld_done (out, 1, pulse) and ld_data (out, 32).
REQ-005 SHALL have st_req (in, 1), st_addr (in, 32), st_op (in, 6), st_data (in, 32), st_gnt (out, 1, pulse) and st_done (out, 1, pulse).
REQ-006 SHALL have if_req (in, 1), if_pc (in, 32), if_gnt (out, 1, pulse), if_done (out, 1, pulse), if_inst (out, 32) and if_pc_out (out, 32, PC of the returned instruction).
REQ-007 SHALL drive the downstream controller through mc_valid (out, 1, one-cycle command strobe), mc_kind (out, 2; 00 fetch, 01 load, 10 store), mc_addr (out, 32), mc_op (out, 6) and mc_wdata (out, 32).
REQ-008 SHALL receive mc_done (in, 1, pulse when the controller finishes) and mc_rdata (in, 32, valid with mc_done).

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, BUSY and DRAIN, all outputs registered.
REQ-010 IDLE: at a clock edge with at least one eligible request, SHALL latch the winner's kind, address, op and data and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-011 ISSUE (exactly 1 cycle): SHALL hold mc_valid=1 and pulse the winner's *_gnt=1 in the same cycle, then go to BUSY.
REQ-012 BUSY: on mc_done, SHALL pulse the matching *_done for 1 cycle and go to IDLE.
  - Load: ld_data=mc_rdata.
  - Fetch: if_inst=mc_rdata and if_pc_out=latched PC.
REQ-013 mc_done SHALL be ignored in IDLE and ISSUE.
REQ-014 Priority SHALL be store > load > fetch.
REQ-015 Override: when starve_cnt == STARVE_LIMIT and if_req=1, fetch SHALL win.
REQ-016 starve_cnt (3-bit, saturating at STARVE_LIMIT) behaviour:
  - +1 on each load or store grant while if_req=1.
  - Cleared on a fetch grant, whenever if_req=0 in IDLE, and on roll_back.
REQ-017 A store SHALL be ineligible when st_addr[17:16]==2'b11 and io_buffer_full=1; loads and fetches SHALL then still be arbitrated.
REQ-018 Fastest request-to-done latency SHALL be: request sampled at edge N, gnt and mc_valid during cycle N+1, *_done the cycle after the mc_done edge.
  - The next arbitration occurs in IDLE one cycle after the *_done pulse.
REQ-019 roll_back in ISSUE or BUSY with a load or fetch SHALL go to DRAIN.
REQ-020 DRAIN SHALL wait for mc_done, suppress ld_done/if_done, then go to IDLE.
REQ-021 roll_back with a store in progress SHALL NOT abort it; st_done SHALL still be delivered.
REQ-022 roll_back in IDLE SHALL inhibit arbitration that cycle; requests sampled in the same cycle SHALL be dropped.
REQ-023 rdy_in=0 SHALL hold FSM, latched command, starve_cnt and all outputs; a pulse in progress SHALL extend until rdy_in returns.
REQ-024 Simultaneous mc_done and roll_back in BUSY on a load or fetch SHALL suppress the done pulse and go to IDLE.

Reset
REQ-025 rst_in=0 SHALL asynchronously force state IDLE, starve_cnt=0, all *_gnt, *_done and mc_valid to 0, and mc_kind, mc_addr, mc_op, mc_wdata, ld_data, if_inst and if_pc_out to 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no done pulse after release; the first arbitration SHALL occur at the first clock edge after rst_in rises.

Verification
REQ-027 Stimulus: st_req, ld_req and if_req asserted together, mc_done 3 cycles after each mc_valid. Required response: grant order store, load, fetch; exactly one mc_valid per grant.
REQ-028 Stimulus: ld_req held high continuously, if_req high, STARVE_LIMIT=4. Required response: 4 load grants, then fetch granted 5th; starve_cnt returns to 0.
REQ-029 Stimulus: st_addr=0x00030000, io_buffer_full=1, ld_req=1. Required response: load granted, store waits; after io_buffer_full=0, store granted next IDLE.
REQ-030 Stimulus: fetch in BUSY, roll_back pulsed, mc_done 2 cycles later with mc_rdata=0xDEADBEEF. Required response: no if_done, FSM reaches IDLE after mc_done; a store in BUSY under the same stimulus still gives st_done.
REQ-031 Stimulus: rdy_in=0 for 3 cycles during an ld_done pulse. Required response: ld_done and ld_data held 3 cycles, then deasserted 1 cycle after rdy_in=1.
REQ-032 Stimulus: rst_in=0 asserted asynchronously mid-BUSY. Required response: all outputs 0 immediately, no stale done after release.
